eth_mdio_master: RTL

Clause-22 MDIO management master for the Ethernet PHY, living in the top-level Ethernet glue beside the MDIO IOBUF. It accepts single register read/write requests from the soft-core bus bridge over a valid/ready handshake. It serialises each request into a 64-bit MDC/MDIO frame and returns read data with a response pulse. It also sequences the PHY hardware reset (`eth_rst_n`) after system reset.

---
 rtl/eth_mdio_master.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_mdio_master.sv
// -----------------------------------------------------------------------------
// eth_mdio_master
//
// Clause-22 MDIO management master. It takes single PHY register read/write
// requests, shifts each one out as a 64-bit MDC/MDIO frame and returns the read
// data with a one-cycle response pulse. It also sequences the PHY hardware
// reset (eth_rst_n) after system reset.
//
// Optional feature macro: ETH_PHY_RST_SEQ_EN
//   defined   : after rst, eth_rst_n is held low for RST_HOLD_CYCLES, then the
//               block waits RST_WAIT_CYCLES before it accepts the first request.
//   undefined : eth_rst_n is 0 during rst and 1 from the first clock after it;
//               the master is idle immediately.
//
// Parameters:
//   CLK_DIV          sys_clk cycles per MDC half-period (minimum 2)
//   RST_HOLD_CYCLES  eth_rst_n low time after reset (macro only)
//   RST_WAIT_CYCLES  delay from eth_rst_n rising to the first accept (macro only)
//
// Ports:
//   sys_clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready        request handshake
//   req_write                    1 = write, 0 = read
//   req_phy_addr, req_reg_addr   5-bit PHY and register addresses
//   req_wdata                    16-bit write data
//   rsp_valid                    one-cycle completion pulse
//   rsp_rdata                    read data, held until the next read completes
//   rsp_err                      read turnaround bit was 1 (valid with rsp_valid)
//   busy                         high from accept through the rsp_valid cycle
//   eth_rst_n                    PHY reset, active-low
//   eth_mdio_mdc                 MDC
//   eth_mdio_mdio_o/_i/_t        MDIO IOBUF pins; _t = 1 releases the line
//
// Handshake: a request is accepted in any cycle where req_valid && req_ready
// are both 1. req_ready is 1 only in IDLE; all request fields are captured in
// the accept cycle and the inputs are ignored until the master is idle again.
// -----------------------------------------------------------------------------
module eth_mdio_master #(
  parameter int CLK_DIV         = 25,
  parameter int RST_HOLD_CYCLES = 1000000,
  parameter int RST_WAIT_CYCLES = 5000000
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy_addr,
  input  logic [4:0]  req_reg_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        eth_rst_n,
  output logic        eth_mdio_mdc,
  output logic        eth_mdio_mdio_o,
  input  logic        eth_mdio_mdio_i,
  output logic        eth_mdio_mdio_t
);

  // Elaboration-time sanity checks on the configuration.
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("eth_mdio_master: CLK_DIV must be at least 2");
  end
  if (RST_HOLD_CYCLES < 1 || RST_WAIT_CYCLES < 1) begin : g_bad_rst_cycles
    $error("eth_mdio_master: reset sequence cycle counts must be at least 1");
  end

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Frame bit positions (bit 0 is the first bit on the wire).
  localparam logic [5:0] BIT_TA_FIRST = 6'd46;
  localparam logic [5:0] BIT_TA_LAST  = 6'd47;
  localparam logic [5:0] BIT_DATA0    = 6'd48;
  localparam logic [5:0] BIT_LAST     = 6'd63;

  typedef enum logic [2:0] {
`ifdef ETH_PHY_RST_SEQ_EN
    PHY_RST_HOLD = 3'd0,
    PHY_RST_WAIT = 3'd1,
`endif
    IDLE         = 3'd2,
    SHIFT        = 3'd3,
    DONE         = 3'd4
  } state_e;

`ifdef ETH_PHY_RST_SEQ_EN
  localparam state_e RESET_STATE = PHY_RST_HOLD;
  localparam logic   READY_RST   = 1'b0;
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST = 32'(RST_WAIT_CYCLES - 1);
  logic [31:0] seq_cnt_q, seq_cnt_d;
`else
  localparam state_e RESET_STATE = IDLE;
  localparam logic   READY_RST   = 1'b1;
`endif

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [5:0]         bit_idx_q, bit_idx_d;
  logic [63:0]        frame_q, frame_d;     // bit 63 is the bit currently on the wire
  logic               is_read_q, is_read_d;
  logic [15:0]        rd_sh_q, rd_sh_d;     // read data shift-in, MSB first
  logic               ta_err_q, ta_err_d;   // sampled second turnaround bit
  logic               mdc_q, mdc_d;
  logic               mdio_o_q, mdio_o_d;
  logic               mdio_t_q, mdio_t_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [15:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;
  logic               req_ready_q, req_ready_d;
  logic               eth_rst_n_q, eth_rst_n_d;

  logic               handshake;
  logic               div_wrap;
  logic               sample_now;

  assign handshake  = req_valid && req_ready_q;
  assign div_wrap   = (div_cnt_q == DIV_LAST);
  // First high cycle of each bit: the PHY has had a full low half-period to
  // drive its value, so this is where mdio_i is taken.
  assign sample_now = mdc_q && (div_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    is_read_d   = is_read_q;
    rd_sh_d     = rd_sh_q;
    ta_err_d    = ta_err_q;
    mdc_d       = mdc_q;
    mdio_o_d    = mdio_o_q;
    mdio_t_d    = mdio_t_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    req_ready_d = req_ready_q;
`ifdef ETH_PHY_RST_SEQ_EN
    seq_cnt_d   = seq_cnt_q;
    eth_rst_n_d = eth_rst_n_q;
`else
    eth_rst_n_d = 1'b1;
`endif

    case (state_q)
`ifdef ETH_PHY_RST_SEQ_EN
      PHY_RST_HOLD: begin
        if (seq_cnt_q == HOLD_LAST) begin
          state_d     = PHY_RST_WAIT;
          seq_cnt_d   = '0;
          eth_rst_n_d = 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + 32'd1;
        end
      end

      PHY_RST_WAIT: begin
        if (seq_cnt_q == WAIT_LAST) begin
          state_d     = IDLE;
          seq_cnt_d   = '0;
          req_ready_d = 1'b1;
        end else begin
          seq_cnt_d = seq_cnt_q + 32'd1;
        end
      end
`endif

      IDLE: begin
        if (handshake) begin
          state_d   = SHIFT;
          // Read frames carry 1s in TA/DATA; the line is released there anyway.
          frame_d   = {32'hFFFF_FFFF, 2'b01,
                       (req_write ? 2'b01 : 2'b10),
                       req_phy_addr, req_reg_addr,
                       (req_write ? 2'b10 : 2'b11),
                       (req_write ? req_wdata : 16'hFFFF)};
          is_read_d   = !req_write;
          div_cnt_d   = '0;
          bit_idx_d   = '0;
          rd_sh_d     = '0;
          ta_err_d    = 1'b0;
          mdc_d       = 1'b0;
          mdio_o_d    = 1'b1;   // bit 0 is preamble
          mdio_t_d    = 1'b0;
          busy_d      = 1'b1;
          req_ready_d = 1'b0;
        end
      end

      SHIFT: begin
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;

        if (sample_now && is_read_q) begin
          if (bit_idx_q == BIT_TA_LAST) begin
            ta_err_d = eth_mdio_mdio_i;
          end
          if (bit_idx_q >= BIT_DATA0) begin
            rd_sh_d = {rd_sh_q[14:0], eth_mdio_mdio_i};
          end
        end

        if (div_wrap) begin
          if (!mdc_q) begin
            mdc_d = 1'b1;
          end else begin
            // Falling MDC edge: the only place mdio_o/mdio_t move.
            mdc_d = 1'b0;
            if (bit_idx_q == BIT_LAST) begin
              state_d     = DONE;
              mdio_o_d    = 1'b1;
              mdio_t_d    = 1'b1;
              rsp_valid_d = 1'b1;
              if (is_read_q) begin
                rsp_rdata_d = rd_sh_q;
                rsp_err_d   = ta_err_q;
              end else begin
                rsp_err_d   = 1'b0;
              end
            end else begin
              bit_idx_d = bit_idx_q + 6'd1;
              frame_d   = {frame_q[62:0], 1'b1};
              mdio_o_d  = frame_q[62];
              // Release the line from the first TA bit of a read onward.
              mdio_t_d  = is_read_q && (bit_idx_q >= (BIT_TA_FIRST - 6'd1));
            end
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        mdc_d       = 1'b0;
        mdio_o_d    = 1'b1;
        mdio_t_d    = 1'b1;
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q     <= RESET_STATE;
      div_cnt_q   <= '0;
      bit_idx_q   <= '0;
      frame_q     <= '1;
      is_read_q   <= 1'b0;
      rd_sh_q     <= '0;
      ta_err_q    <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_t_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= READY_RST;
      eth_rst_n_q <= 1'b0;
`ifdef ETH_PHY_RST_SEQ_EN
      seq_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_idx_q   <= bit_idx_d;
      frame_q     <= frame_d;
      is_read_q   <= is_read_d;
      rd_sh_q     <= rd_sh_d;
      ta_err_q    <= ta_err_d;
      mdc_q       <= mdc_d;
      mdio_o_q    <= mdio_o_d;
      mdio_t_q    <= mdio_t_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      eth_rst_n_q <= eth_rst_n_d;
`ifdef ETH_PHY_RST_SEQ_EN
      seq_cnt_q   <= seq_cnt_d;
`endif
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_err         = rsp_err_q;
  assign busy            = busy_q;
  assign eth_rst_n       = eth_rst_n_q;
  assign eth_mdio_mdc    = mdc_q;
  assign eth_mdio_mdio_o = mdio_o_q;
  assign eth_mdio_mdio_t = mdio_t_q;

endmodule
